frame_capture_sequencer: RTL and testbench

Sequences one pixel-array capture: erase, programmable exposure, row-by-row ADC conversion of the two pixel rows, and transfer of the four converted samples over a valid/ready stream. It drives the control pins of the pixel electronics (NRE_1, NRE_2, ADC, Expose, Erase). It owns the user-adjustable exposure time, and sits between the camera buttons and the downstream frame consumer.

---
 rtl/camera_pkg.sv | 38 +++
 rtl/exposure_reg.sv | 66 ++++++
 rtl/frame_capture_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_frame_capture_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// camera_pkg
//   Shared definitions for the frame capture path: the capture FSM state
//   encoding, the default parameter set of the sequencer, and a helper that
//   sizes the shared phase down-counter.
//   Also imported by the pixel-electronics models, so the state names and
//   defaults must stay stable.
package camera_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ERASE  = 3'd1,
    EXPOSE = 3'd2,
    CONV1  = 3'd3,
    OUT1   = 3'd4,
    CONV2  = 3'd5,
    OUT2   = 3'd6
  } state_t;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_EXP_W     = 5;
  localparam int DEF_EXP_MIN   = 2;
  localparam int DEF_EXP_MAX   = 30;
  localparam int DEF_EXP_INIT  = 16;
  localparam int DEF_ERASE_CYC = 4;
  localparam int DEF_ADC_CYC   = 8;

  // One counter serves erase, exposure and conversion, so it must be wide
  // enough for the largest of the three reload values.
  function automatic int cnt_width(input int exp_w, input int erase_cyc,
                                   input int adc_cyc);
    int w;
    w = exp_w;
    if ($clog2(erase_cyc) > w) w = $clog2(erase_cyc);
    if ($clog2(adc_cyc) > w) w = $clog2(adc_cyc);
    return w;
  endfunction

endpackage

// File: rtl/exposure_reg.sv
// exposure_reg
//   Button edge detection plus the saturating exposure-time register.
//   Edges are only applied while i_en is high (sequencer idle); edges seen
//   while disabled are dropped, but the history registers keep tracking the
//   inputs so a button held through a frame does not fire afterwards.
// Ports
//   i_clk       system clock
//   i_rst       asynchronous active-high reset
//   i_inc       exposure increase button level
//   i_dec       exposure decrease button level
//   i_en        apply detected edges
//   o_exp_time  current exposure setting, cycles
module exposure_reg
  import camera_pkg::*;
#(
  parameter int EXP_W    = DEF_EXP_W,
  parameter int EXP_MIN  = DEF_EXP_MIN,
  parameter int EXP_MAX  = DEF_EXP_MAX,
  parameter int EXP_INIT = DEF_EXP_INIT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_en,
  output logic [EXP_W-1:0] o_exp_time
);

  logic             r_inc_q;
  logic             r_dec_q;
  logic [EXP_W-1:0] r_exp;
  logic             w_inc_edge;
  logic             w_dec_edge;

  // Simultaneous up and down cancel; each direction clamps at its limit.
  function automatic logic [EXP_W-1:0] sat_step(input logic [EXP_W-1:0] v,
                                                input logic up,
                                                input logic dn);
    logic [EXP_W-1:0] nv;
    nv = v;
    if (up && !dn && (v < EXP_W'(EXP_MAX)))
      nv = v + EXP_W'(1);
    else if (dn && !up && (v > EXP_W'(EXP_MIN)))
      nv = v - EXP_W'(1);
    return nv;
  endfunction

  assign w_inc_edge = i_inc & ~r_inc_q;
  assign w_dec_edge = i_dec & ~r_dec_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inc_q <= 1'b0;
      r_dec_q <= 1'b0;
      r_exp   <= EXP_W'(EXP_INIT);
    end else begin
      r_inc_q <= i_inc;
      r_dec_q <= i_dec;
      if (i_en)
        r_exp <= sat_step(r_exp, w_inc_edge, w_dec_edge);
    end
  end

  assign o_exp_time = r_exp;

endmodule

// File: rtl/frame_capture_sequencer.sv
// frame_capture_sequencer
//   Runs one capture of the 2x2 pixel array per Init edge: erase, exposure
//   of the latched length, then for each row a conversion window followed by
//   streaming that row's two samples over a valid/ready interface.
// Ports
//   Clk, Reset            clock, asynchronous active-high reset
//   Exp_increase/decrease button levels, rising edge adjusts exposure (idle only)
//   Init                  rising edge starts a capture (idle only)
//   ADC_1_in, ADC_2_in    column samples of the enabled row
//   NRE_1, NRE_2          row read enables, active-low
//   ADC, Expose, Erase    pixel-electronics control strobes
//   Pix_data/valid/ready  sample stream to the frame consumer
//   Busy                  high outside IDLE
//   Exp_time              current exposure setting
//   Frame_count           completed frames, wrapping
module frame_capture_sequencer
  import camera_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int EXP_W     = DEF_EXP_W,
  parameter int EXP_MIN   = DEF_EXP_MIN,
  parameter int EXP_MAX   = DEF_EXP_MAX,
  parameter int EXP_INIT  = DEF_EXP_INIT,
  parameter int ERASE_CYC = DEF_ERASE_CYC,
  parameter int ADC_CYC   = DEF_ADC_CYC
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Exp_increase,
  input  logic              Exp_decrease,
  input  logic              Init,
  input  logic [DATA_W-1:0] ADC_1_in,
  input  logic [DATA_W-1:0] ADC_2_in,
  output logic              NRE_1,
  output logic              NRE_2,
  output logic              ADC,
  output logic              Expose,
  output logic              Erase,
  output logic [DATA_W-1:0] Pix_data,
  output logic              Pix_valid,
  input  logic              Pix_ready,
  output logic              Busy,
  output logic [EXP_W-1:0]  Exp_time,
  output logic [7:0]        Frame_count
);

  localparam int CNT_W = cnt_width(EXP_W, ERASE_CYC, ADC_CYC);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [EXP_W-1:0]  r_exp_lat;
  logic              r_init_q;
  logic              r_word;
  logic              r_nre1;
  logic              r_nre2;
  logic              r_adc;
  logic              r_expose;
  logic              r_erase;
  logic              r_pix_valid;
  logic [DATA_W-1:0] r_pix_data;
  logic [DATA_W-1:0] r_buf1;
  logic [7:0]        r_frame_cnt;

  logic              w_init_edge;
  logic              w_cnt_done;
  logic              w_hs;
  logic              w_idle;
  logic              w_capture;
  logic [EXP_W-1:0]  w_exp_time;

  assign w_idle      = (r_state == IDLE);
  assign w_init_edge = Init & ~r_init_q;
  assign w_cnt_done  = (r_cnt == '0);
  assign w_hs        = r_pix_valid & Pix_ready;
  assign w_capture   = ((r_state == CONV1) || (r_state == CONV2)) && w_cnt_done;

  exposure_reg #(
    .EXP_W    (EXP_W),
    .EXP_MIN  (EXP_MIN),
    .EXP_MAX  (EXP_MAX),
    .EXP_INIT (EXP_INIT)
  ) u_exposure_reg (
    .i_clk      (Clk),
    .i_rst      (Reset),
    .i_inc      (Exp_increase),
    .i_dec      (Exp_decrease),
    .i_en       (w_idle),
    .o_exp_time (w_exp_time)
  );

  // Sample buffer: entry 0 of the row is loaded straight into the output
  // register at capture, so only entry 1 needs separate storage.
  always_ff @(posedge Clk) begin
    if (w_capture)
      r_buf1 <= ADC_2_in;
  end

  // Each timed phase loads r_cnt with (length - 1) on entry and leaves on
  // the edge where it reads zero, giving exactly 'length' cycles.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_exp_lat   <= '0;
      r_init_q    <= 1'b0;
      r_word      <= 1'b0;
      r_nre1      <= 1'b1;
      r_nre2      <= 1'b1;
      r_adc       <= 1'b0;
      r_expose    <= 1'b0;
      r_erase     <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_init_q <= Init;
      case (r_state)
        IDLE: begin
          if (w_init_edge) begin
            r_exp_lat <= w_exp_time;
            r_cnt     <= CNT_W'(ERASE_CYC - 1);
            r_erase   <= 1'b1;
            r_state   <= ERASE;
          end
        end
        ERASE: begin
          if (w_cnt_done) begin
            r_erase  <= 1'b0;
            r_expose <= 1'b1;
            r_cnt    <= CNT_W'(r_exp_lat) - CNT_W'(1);
            r_state  <= EXPOSE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        EXPOSE: begin
          if (w_cnt_done) begin
            r_expose <= 1'b0;
            r_nre1   <= 1'b0;
            r_adc    <= 1'b1;
            r_cnt    <= CNT_W'(ADC_CYC - 1);
            r_state  <= CONV1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        CONV1, CONV2: begin
          if (w_cnt_done) begin
            r_nre1      <= 1'b1;
            r_nre2      <= 1'b1;
            r_adc       <= 1'b0;
            r_pix_data  <= ADC_1_in;
            r_pix_valid <= 1'b1;
            r_word      <= 1'b0;
            r_state     <= (r_state == CONV1) ? OUT1 : OUT2;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        OUT1, OUT2: begin
          if (w_hs) begin
            if (!r_word) begin
              r_pix_data <= r_buf1;
              r_word     <= 1'b1;
            end else begin
              r_pix_valid <= 1'b0;
              r_word      <= 1'b0;
              if (r_state == OUT1) begin
                r_nre2  <= 1'b0;
                r_adc   <= 1'b1;
                r_cnt   <= CNT_W'(ADC_CYC - 1);
                r_state <= CONV2;
              end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
                r_state     <= IDLE;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign NRE_1       = r_nre1;
  assign NRE_2       = r_nre2;
  assign ADC         = r_adc;
  assign Expose      = r_expose;
  assign Erase       = r_erase;
  assign Pix_data    = r_pix_data;
  assign Pix_valid   = r_pix_valid;
  assign Busy        = ~w_idle;
  assign Exp_time    = w_exp_time;
  assign Frame_count = r_frame_cnt;

endmodule

// File: tb/tb_frame_capture_sequencer.sv
// tb_frame_capture_sequencer
//   Directed bench for frame_capture_sequencer. Stream words are predicted
//   into a queue when the ADC inputs are driven and checked on handshake;
//   control timing is checked cycle by cycle inside the frame task.
module tb_frame_capture_sequencer;

  localparam int ERASE_CYC = 4;
  localparam int ADC_CYC   = 8;

  logic       Clk;
  logic       Reset;
  logic       Exp_increase;
  logic       Exp_decrease;
  logic       Init;
  logic [7:0] ADC_1_in;
  logic [7:0] ADC_2_in;
  logic       NRE_1;
  logic       NRE_2;
  logic       ADC;
  logic       Expose;
  logic       Erase;
  logic [7:0] Pix_data;
  logic       Pix_valid;
  logic       Pix_ready;
  logic       Busy;
  logic [4:0] Exp_time;
  logic [7:0] Frame_count;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] q[$];

  frame_capture_sequencer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Exp_increase (Exp_increase),
    .Exp_decrease (Exp_decrease),
    .Init         (Init),
    .ADC_1_in     (ADC_1_in),
    .ADC_2_in     (ADC_2_in),
    .NRE_1        (NRE_1),
    .NRE_2        (NRE_2),
    .ADC          (ADC),
    .Expose       (Expose),
    .Erase        (Erase),
    .Pix_data     (Pix_data),
    .Pix_valid    (Pix_valid),
    .Pix_ready    (Pix_ready),
    .Busy         (Busy),
    .Exp_time     (Exp_time),
    .Frame_count  (Frame_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are settled and new inputs can be driven.
  task automatic cyc();
    @(posedge Clk);
    #2;
  endtask

  task automatic press(input logic inc, input logic dec);
    Exp_increase = inc;
    Exp_decrease = dec;
    cyc();
    Exp_increase = 1'b0;
    Exp_decrease = 1'b0;
    cyc();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_nre1"},   32'(NRE_1), 32'd1);
    chk({tag, "_nre2"},   32'(NRE_2), 32'd1);
    chk({tag, "_adc"},    32'(ADC), 32'd0);
    chk({tag, "_expose"}, 32'(Expose), 32'd0);
    chk({tag, "_erase"},  32'(Erase), 32'd0);
    chk({tag, "_valid"},  32'(Pix_valid), 32'd0);
    chk({tag, "_data"},   32'(Pix_data), 32'd0);
    chk({tag, "_busy"},   32'(Busy), 32'd0);
    chk({tag, "_exp"},    32'(Exp_time), 32'd16);
    chk({tag, "_fcnt"},   32'(Frame_count), 32'd0);
  endtask

  // One capture. stall: cycles Pix_ready is held low on the first word of
  // row 1. disturb: Init and Exp_increase pulsed during exposure. abort:
  // Reset asserted in the middle of the row-2 conversion.
  task automatic frame(input int expv, input int stall, input bit disturb,
                       input bit abort, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] d);
    int busy_n;
    busy_n = 0;
    Pix_ready = (stall == 0);
    Init = 1'b1;
    cyc();
    Init = 1'b0;
    for (int i = 0; i < ERASE_CYC; i++) begin
      chk("erase_hi", 32'(Erase), 32'd1);
      chk("erase_no_expose", 32'(Expose), 32'd0);
      busy_n += int'(Busy);
      cyc();
    end
    for (int i = 0; i < expv; i++) begin
      chk("expose_hi", 32'(Expose), 32'd1);
      chk("expose_no_erase", 32'(Erase), 32'd0);
      busy_n += int'(Busy);
      Init         = (disturb && i == 1);
      Exp_increase = (disturb && i == 1);
      cyc();
    end
    Init         = 1'b0;
    Exp_increase = 1'b0;
    ADC_1_in = a;
    ADC_2_in = b;
    q.push_back(a);
    q.push_back(b);
    for (int i = 0; i < ADC_CYC; i++) begin
      chk("row1_nre", 32'(NRE_1), 32'd0);
      chk("row1_adc", 32'(ADC), 32'd1);
      busy_n += int'(Busy);
      cyc();
    end
    for (int i = 0; i < stall; i++) begin
      chk("hold_valid", 32'(Pix_valid), 32'd1);
      chk("hold_data", 32'(Pix_data), 32'(a));
      chk("hold_nre2", 32'(NRE_2), 32'd1);
      busy_n += int'(Busy);
      cyc();
    end
    Pix_ready = 1'b1;
    chk("w0_valid", 32'(Pix_valid), 32'd1);
    chk("w0_nre1", 32'(NRE_1), 32'd1);
    busy_n += int'(Busy);
    cyc();
    chk("w1_valid", 32'(Pix_valid), 32'd1);
    busy_n += int'(Busy);
    cyc();
    ADC_1_in = c;
    ADC_2_in = d;
    if (!abort) begin
      q.push_back(c);
      q.push_back(d);
    end
    for (int i = 0; i < ADC_CYC; i++) begin
      chk("row2_nre", 32'(NRE_2), 32'd0);
      chk("row2_adc", 32'(ADC), 32'd1);
      if (abort && i == 3) begin
        Reset = 1'b1;
        #1;
        chk_reset("abort");
        cyc();
        Reset = 1'b0;
        cyc();
        return;
      end
      busy_n += int'(Busy);
      cyc();
    end
    chk("w2_valid", 32'(Pix_valid), 32'd1);
    busy_n += int'(Busy);
    cyc();
    chk("w3_valid", 32'(Pix_valid), 32'd1);
    busy_n += int'(Busy);
    cyc();
    chk("busy_cycles", 32'(busy_n), 32'(ERASE_CYC + expv + 2 * (ADC_CYC + 2) + stall));
    chk("end_busy", 32'(Busy), 32'd0);
    chk("end_valid", 32'(Pix_valid), 32'd0);
  endtask

  // Stream scoreboard and control-exclusion checks, sampled mid-cycle.
  always @(negedge Clk) begin
    if (!Reset) begin
      chk("ctrl_exclusive", 32'($onehot0({Erase, Expose, ~NRE_1, ~NRE_2})), 32'd1);
      chk("adc_with_row", 32'(!ADC || (NRE_1 ^ NRE_2)), 32'd1);
      if (Pix_valid && Pix_ready) begin
        n_cmp++;
        assert (q.size() > 0) else begin
          n_err++;
          $error("FAIL pix_unexpected: observed word %0h, expected none", Pix_data);
        end
        if (q.size() > 0) chk("pix_word", 32'(Pix_data), 32'(q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end of run, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rb[12];
    for (int i = 0; i < 12; i++) rb[i] = 8'($urandom);
    Reset        = 1'b1;
    Exp_increase = 1'b0;
    Exp_decrease = 1'b0;
    Init         = 1'b0;
    ADC_1_in     = 8'h00;
    ADC_2_in     = 8'h00;
    Pix_ready    = 1'b0;
    #1;
    chk_reset("in_reset");
    cyc();
    cyc();
    Reset = 1'b0;
    cyc();
    chk_reset("after_reset");

    for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
    chk("exp_inc3", 32'(Exp_time), 32'd19);
    for (int i = 0; i < 40; i++) press(1'b0, 1'b1);
    chk("exp_min_sat", 32'(Exp_time), 32'd2);
    for (int i = 0; i < 40; i++) press(1'b1, 1'b0);
    chk("exp_max_sat", 32'(Exp_time), 32'd30);
    press(1'b0, 1'b1);
    chk("exp_dec1", 32'(Exp_time), 32'd29);
    press(1'b1, 1'b1);
    chk("exp_both", 32'(Exp_time), 32'd29);

    frame(29, 0, 1'b0, 1'b1, rb[0], rb[1], rb[2], rb[3]);
    chk("abort_fcnt", 32'(Frame_count), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);

    for (int i = 0; i < 11; i++) press(1'b0, 1'b1);
    chk("exp_set5", 32'(Exp_time), 32'd5);

    frame(5, 0, 1'b0, 1'b0, 8'h11, 8'h22, 8'h33, 8'h44);
    chk("fcnt1", 32'(Frame_count), 32'd1);
    chk("exp_kept1", 32'(Exp_time), 32'd5);

    frame(5, 10, 1'b0, 1'b0, rb[4], rb[5], rb[6], rb[7]);
    chk("fcnt2", 32'(Frame_count), 32'd2);

    frame(5, 0, 1'b1, 1'b0, rb[8], rb[9], rb[10], rb[11]);
    chk("fcnt3", 32'(Frame_count), 32'd3);
    chk("exp_busy_ignored", 32'(Exp_time), 32'd5);

    cyc();
    chk("idle_after_disturb", 32'(Busy), 32'd0);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
